// File: rtl/note_sequencer.sv
// Note sequencer: fetches {pitch,length} per note from song RAM, pulses the length-counter
// init, then enables counting until finish_len; supports pause, stop and looping playback.
module note_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int PITCH_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               mode,
  input  logic               loop_en,
  input  logic [ADDR_W:0]    song_len,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [PITCH_W+1:0] rd_data,
  input  logic               finish_len,
  output logic               Init_audio_video,
  output logic               Do_rand_audio_video,
  output logic               Do_save_audio_video,
  output logic [1:0]         length,
  output logic [PITCH_W-1:0] pitch,
  output logic               note_valid,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t               r_state, w_state_next;
  logic [ADDR_W-1:0]    r_addr, w_addr_next;
  logic [PITCH_W-1:0]   r_pitch, w_pitch_next;
  logic [1:0]           r_len, w_len_next;
  logic                 r_mode, r_loop;
  logic [ADDR_W:0]      r_song_len;
  logic                 w_cfg_load, w_init, w_do_en, w_done, w_last;

  // Last note when the address reaches song_len_q-1 (song_len_q is never 0 outside IDLE/DONE).
  assign w_last = ({1'b0, r_addr} == (r_song_len - 1'b1));

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_pitch_next = r_pitch;
    w_len_next   = r_len;
    w_cfg_load   = 1'b0;
    w_init       = 1'b0;
    w_do_en      = 1'b0;
    w_done       = 1'b0;
    if (stop && (r_state != S_IDLE)) begin
      // Abort: clear the length counter on the way out.
      w_state_next = S_IDLE;
      w_init       = 1'b1;
      w_addr_next  = '0;
      w_pitch_next = '0;
      w_len_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            w_cfg_load   = 1'b1;
            w_addr_next  = '0;
            w_state_next = (song_len == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: w_state_next = S_LOAD;
        S_LOAD: begin
          w_pitch_next = rd_data[PITCH_W+1:2];
          w_len_next   = rd_data[1:0];
          w_init       = 1'b1;
          w_state_next = S_PLAY;
        end
        S_PLAY: begin
          if (finish_len) begin
            if (!w_last) begin
              w_addr_next  = r_addr + 1'b1;
              w_state_next = S_FETCH;
            end else if (r_loop) begin
              w_addr_next  = '0;
              w_state_next = S_FETCH;
            end else begin
              w_state_next = S_DONE;
            end
          end else begin
            w_do_en = 1'b1;
            if (pause) w_state_next = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (!pause) w_state_next = S_PLAY;
        end
        S_DONE: begin
          w_done       = 1'b1;
          w_addr_next  = '0;
          w_pitch_next = '0;
          w_len_next   = '0;
          w_state_next = S_IDLE;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_pitch    <= '0;
      r_len      <= '0;
      r_mode     <= 1'b0;
      r_loop     <= 1'b0;
      r_song_len <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_pitch <= w_pitch_next;
      r_len   <= w_len_next;
      if (w_cfg_load) begin
        r_mode     <= mode;
        r_loop     <= loop_en;
        r_song_len <= song_len;
      end
    end
  end

  assign rd_addr             = r_addr;
  assign pitch               = r_pitch;
  assign length              = r_len;
  assign Init_audio_video    = w_init;
  assign Do_rand_audio_video = w_do_en & ~r_mode;
  assign Do_save_audio_video = w_do_en & r_mode;
  assign note_valid          = (r_state == S_PLAY) && (r_pitch != '0);
  assign busy                = (r_state != S_IDLE);
  assign done                = w_done;
  assign state_dbg           = r_state;

endmodule
